// File: rtl/clock_divider_bank.sv
`default_nettype none
// ============================================================================
// clock_divider_bank : NCH glitch-free programmable dividers (tick + square)
// Revision: 1.0
// ============================================================================
module clock_divider_bank #(
  parameter int FREQ_IN  = 100,
  parameter int FREQ_OUT = 20,
  parameter int W        = 3,
  parameter int NCH      = 2,
  localparam int CW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            clk_in,
  input  logic            rst,
  input  logic [NCH-1:0]  ch_en,
  input  logic            cfg_valid,
  input  logic [CW-1:0]   cfg_sel,
  input  logic [W-1:0]    cfg_div,
  output logic            cfg_ready,
  output logic [NCH-1:0]  tick,
  output logic [NCH-1:0]  clk_out
);

  localparam int DEFAULT_DIV = FREQ_IN / FREQ_OUT;
  localparam logic [W-1:0] C_DEFAULT_DIV = W'(DEFAULT_DIV);

  if (DEFAULT_DIV > (2**W) - 1) begin : g_bad_default_div
    $error("clock_divider_bank: DEFAULT_DIV does not fit in W bits");
  end

  logic [NCH-1:0] pend_vec;
  logic           sel_pend;

  // Out-of-range selects see no pending flag, so they are always ready.
  always_comb begin
    sel_pend = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (cfg_sel == CW'(i)) sel_pend = pend_vec[i];
    end
    cfg_ready = !rst && !sel_pend;
  end

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] cur_div_q, cur_div_d;
    logic [W-1:0] pend_div_q, pend_div_d;
    logic         pend_q, pend_d;
    logic         tick_q, tick_d;
    logic         clk_out_q, clk_out_d;
    logic         active;
    logic         at_last;
    logic         accept;
    logic         apply;
    logic [W:0]   half_hi;

    assign active  = ch_en[ch] && (cur_div_q != '0);
    assign at_last = (cnt_q == (cur_div_q - W'(1)));
    assign accept  = cfg_valid && cfg_ready && (cfg_sel == CW'(ch));
    // A divisor change lands only on a period boundary or while idle.
    assign apply   = pend_q && (!active || at_last);
    assign half_hi = ({1'b0, cur_div_q} + (W+1)'(1)) >> 1;

    always_comb begin
      tick_d     = active && (cnt_q == '0);
      clk_out_d  = active && ({1'b0, cnt_q} < half_hi);
      cur_div_d  = cur_div_q;
      pend_d     = pend_q;
      pend_div_d = pend_div_q;
      if (apply || !active || at_last) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
      if (apply) begin
        cur_div_d = pend_div_q;
        pend_d    = 1'b0;
      end else if (accept) begin
        pend_d     = 1'b1;
        pend_div_d = cfg_div;
      end
    end

    always_ff @(posedge clk_in) begin
      if (rst) begin
        cnt_q      <= '0;
        cur_div_q  <= C_DEFAULT_DIV;
        pend_q     <= 1'b0;
        pend_div_q <= '0;
        tick_q     <= 1'b0;
        clk_out_q  <= 1'b0;
      end else begin
        cnt_q      <= cnt_d;
        cur_div_q  <= cur_div_d;
        pend_q     <= pend_d;
        pend_div_q <= pend_div_d;
        tick_q     <= tick_d;
        clk_out_q  <= clk_out_d;
      end
    end

    assign pend_vec[ch] = pend_q;
    assign tick[ch]     = tick_q;
    assign clk_out[ch]  = clk_out_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_clock_divider_bank.sv
`default_nettype none
// ============================================================================
// tb_clock_divider_bank : directed self-checking bench, three channels
// Revision: 1.0
// ============================================================================
module tb_clock_divider_bank;

  localparam int W   = 3;
  localparam int NCH = 3;
  localparam int CW  = 2;

  logic           clk_in = 1'b0;
  logic           rst;
  logic [NCH-1:0] ch_en;
  logic           cfg_valid;
  logic [CW-1:0]  cfg_sel;
  logic [W-1:0]   cfg_div;
  logic           cfg_ready;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] clk_out;

  int n_checks = 0;
  int n_errors = 0;

  // Three channels so that select value 3 is a genuine out-of-range target.
  clock_divider_bank #(
    .FREQ_IN  (100),
    .FREQ_OUT (20),
    .W        (W),
    .NCH      (NCH)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .ch_en     (ch_en),
    .cfg_valid (cfg_valid),
    .cfg_sel   (cfg_sel),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .tick      (tick),
    .clk_out   (clk_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Strings give per-edge expected bits for ch0/ch1; ch2 stays disabled (0).
  task automatic run_seq(input string tag, input string t0, input string c0,
                         input string t1, input string c1);
    logic [5:0] exp;
    for (int i = 0; i < t0.len(); i++) begin
      step();
      exp = {1'b0, c1[i] == 8'h31, c0[i] == 8'h31,
             1'b0, t1[i] == 8'h31, t0[i] == 8'h31};
      check($sformatf("%s[%0d] {clk_out,tick}", tag, i), 32'({clk_out, tick}), 32'(exp));
    end
  endtask

  task automatic set_cfg(input logic v, input logic [CW-1:0] s, input logic [W-1:0] d);
    cfg_valid = v;
    cfg_sel   = s;
    cfg_div   = d;
  endtask

  initial begin
    rst = 1'b1;
    ch_en = 3'b011;
    set_cfg(1'b0, 2'd0, 3'd0);
    step();
    step();
    check("rst_tick", 32'(tick), 32'h0);
    check("rst_clk_out", 32'(clk_out), 32'h0);
    check("rst_ready", 32'(cfg_ready), 32'h0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(cfg_ready), 32'h1);

    // Defaults: period 5, 3 high / 2 low, channels in phase
    run_seq("t1_default", "1000010000", "1110011100", "1000010000", "1110011100");

    // ch1 -> div 2 written at cnt=1; takes effect after cnt=4
    run_seq("t2_pre", "1", "1", "1", "1");
    set_cfg(1'b1, 2'd1, 3'd2);
    #1;
    check("t2_ready_before", 32'(cfg_ready), 32'h1);
    run_seq("t2_acc", "0", "1", "0", "1");
    cfg_valid = 1'b0;
    #1;
    check("t2_ready_pending", 32'(cfg_ready), 32'h0);
    run_seq("t2_old_a", "00", "10", "00", "10");
    check("t2_ready_still_low", 32'(cfg_ready), 32'h0);
    run_seq("t2_old_b", "0", "0", "0", "0");
    check("t2_ready_applied", 32'(cfg_ready), 32'h1);
    run_seq("t2_new", "100001", "111001", "101010", "101010");

    // ch0 -> div 1, then div 0 (stop), then div 4 (restart)
    set_cfg(1'b1, 2'd0, 3'd1);
    run_seq("t3_acc1", "0", "1", "1", "1");
    cfg_valid = 1'b0;
    #1;
    check("t3_ready_pending", 32'(cfg_ready), 32'h0);
    run_seq("t3_wait1", "000", "100", "010", "010");
    check("t3_ready_applied", 32'(cfg_ready), 32'h1);
    run_seq("t3_div1", "1111", "1111", "1010", "1010");
    set_cfg(1'b1, 2'd0, 3'd0);
    run_seq("t3_acc0", "1", "1", "1", "1");
    cfg_valid = 1'b0;
    run_seq("t3_stopped", "10000", "10000", "01010", "01010");
    set_cfg(1'b1, 2'd0, 3'd4);
    run_seq("t3_acc4", "0", "0", "1", "1");
    cfg_valid = 1'b0;
    run_seq("t3_div4", "010001", "011001", "010101", "010101");

    // Drop ch_en[0] for three cycles mid-period
    ch_en = 3'b010;
    run_seq("t4_off", "000", "000", "010", "010");
    ch_en = 3'b011;
    run_seq("t4_on", "10001", "11001", "10101", "10101");

    // Reset with a pending write on ch1
    set_cfg(1'b1, 2'd1, 3'd3);
    run_seq("t5_acc", "0", "1", "0", "0");
    cfg_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("t5_ready_in_rst", 32'(cfg_ready), 32'h0);
    step();
    check("t5_tick_rst", 32'(tick), 32'h0);
    check("t5_clk_out_rst", 32'(clk_out), 32'h0);
    check("t5_ready_rst_edge", 32'(cfg_ready), 32'h0);
    rst = 1'b0;
    #1;
    check("t5_pending_lost", 32'(cfg_ready), 32'h1);
    run_seq("t5_default", "1000010000", "1110011100", "1000010000", "1110011100");

    // Held valid: ignored select, then back-to-back writes to ch0
    set_cfg(1'b1, 2'd3, 3'd1);
    #1;
    check("t6_ready_sel3", 32'(cfg_ready), 32'h1);
    run_seq("t6_sel3", "1", "1", "1", "1");
    set_cfg(1'b1, 2'd0, 3'd2);
    #1;
    check("t6_ready_first", 32'(cfg_ready), 32'h1);
    run_seq("t6_acc2", "0", "1", "0", "1");
    cfg_div = 3'd3;
    #1;
    check("t6_ready_stall", 32'(cfg_ready), 32'h0);
    run_seq("t6_stall", "000", "100", "000", "100");
    check("t6_ready_second", 32'(cfg_ready), 32'h1);
    run_seq("t6_acc3", "1", "1", "1", "1");
    cfg_valid = 1'b0;
    run_seq("t6_final", "01001", "01101", "00001", "11001");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
